bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 102 ++++++++++
 tb/tb_bit_serializer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - MSB-first word serializer with sof/eof framing; SER_PARITY_EN appends an even-parity bit
module bit_serializer #(
    parameter int DATAWIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATAWIDTH-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 x_o,
    output logic                 bit_vld_o,
    output logic                 sof_o,
    output logic                 eof_o
);

    localparam int CW = $clog2(DATAWIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATAWIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
`ifdef SER_PARITY_EN
        ,
        PARITY = 2'd2
`endif
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        cnt;
    logic [DATAWIDTH-1:0] shreg;
    logic                 accept;
`ifdef SER_PARITY_EN
    logic                 par_bit;
`endif

    assign accept = valid_i & ready_o;

    // Outputs depend only on registered state, so reset clears them without waiting for clk.
    always_comb begin
        state_nxt = state;
        ready_o   = 1'b0;
        bit_vld_o = 1'b0;
        x_o       = 1'b0;
        sof_o     = 1'b0;
        eof_o     = 1'b0;
        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) state_nxt = SHIFT;
            end
            SHIFT: begin
                bit_vld_o = 1'b1;
                x_o       = shreg[DATAWIDTH-1];
                sof_o     = (cnt == '0);
                if (cnt == LAST_CNT) begin
`ifdef SER_PARITY_EN
                    state_nxt = PARITY;
`else
                    eof_o     = 1'b1;
                    ready_o   = 1'b1;
                    state_nxt = valid_i ? SHIFT : IDLE;
`endif
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                bit_vld_o = 1'b1;
                x_o       = par_bit;
                eof_o     = 1'b1;
                ready_o   = 1'b1;
                state_nxt = valid_i ? SHIFT : IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
`ifdef SER_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                shreg <= data_i;
                cnt   <= '0;
`ifdef SER_PARITY_EN
                par_bit <= ^data_i;
`endif
            end else if (state == SHIFT) begin
                shreg <= {shreg[DATAWIDTH-2:0], 1'b0};
                cnt   <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - directed bench for bit_serializer at widths 8, 2 and 64 (64 feeds a divide-by-three model)
module tb_bit_serializer;

`ifdef SER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int WL   = 8 + PB;
    localparam int WL2  = 2 + PB;
    localparam int WL64 = 64 + PB;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [7:0]  data8  = '0;
    logic        valid8 = 1'b0;
    logic        ready8, x8, vld8, sof8, eof8;
    logic [1:0]  data2  = '0;
    logic        valid2 = 1'b0;
    logic        ready2, x2, vld2, sof2, eof2;
    logic [63:0] data64  = '0;
    logic        valid64 = 1'b0;
    logic        ready64, x64, vld64, sof64, eof64;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bit_serializer #(.DATAWIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .data_i(data8), .valid_i(valid8), .ready_o(ready8),
        .x_o(x8), .bit_vld_o(vld8), .sof_o(sof8), .eof_o(eof8));

    bit_serializer #(.DATAWIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .data_i(data2), .valid_i(valid2), .ready_o(ready2),
        .x_o(x2), .bit_vld_o(vld2), .sof_o(sof2), .eof_o(eof2));

    bit_serializer #(.DATAWIDTH(64)) dut64 (
        .clk(clk), .reset(reset), .data_i(data64), .valid_i(valid64), .ready_o(ready64),
        .x_o(x64), .bit_vld_o(vld64), .sof_o(sof64), .eof_o(eof64));

    // Divide-by-three stage: div_o flags that the stream so far, including x_i, is a multiple of 3.
    logic [1:0] rem;
    logic [2:0] rem_t;
    logic [1:0] rem_nxt;
    logic       div_o;
    always_comb begin
        rem_t   = {rem, 1'b0} + {2'b00, x64};
        rem_nxt = (rem_t >= 3'd3) ? 2'(rem_t - 3'd3) : rem_t[1:0];
        div_o   = vld64 & (rem_nxt == 2'd0);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      rem <= 2'd0;
        else if (vld64) rem <= rem_nxt;
    end

    function automatic logic eb8(input logic [7:0] w, input int i);
        return (i <= 8) ? w[8-i] : ^w;
    endfunction

    function automatic logic eb64(input logic [63:0] w, input int i);
        return (i <= 64) ? w[64-i] : ^w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        reset = 1'b1;
        tick();
        got = {x8, vld8, sof8, eof8, ready8};
        total++;
        if (got !== 5'b00001) begin bad++; $display("FAIL reset_held: got %b want 00001", got); end
        reset = 1'b0;
        tick();
        got = {x8, vld8, sof8, eof8, ready8};
        total++;
        if (got !== 5'b00001) begin bad++; $display("FAIL reset_released: got %b want 00001", got); end
    endtask

    task automatic test_single();
        logic [4:0] got, exp;
        data8 = 8'hB4; valid8 = 1'b1;
        for (int i = 1; i <= WL; i++) begin
            tick();
            valid8 = 1'b0;
            got = {x8, vld8, sof8, eof8, ready8};
            exp = {eb8(8'hB4, i), 1'b1, i == 1, i == WL, i == WL};
            total++;
            if (got !== exp) begin bad++; $display("FAIL single_b4 cyc%0d: got %b want %b", i, got, exp); end
        end
        tick();
        got = {x8, vld8, sof8, eof8, ready8};
        total++;
        if (got !== 5'b00001) begin bad++; $display("FAIL single_idle: got %b want 00001", got); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] got, exp;
        logic [7:0] w;
        int j;
        data8 = 8'hFF; valid8 = 1'b1;
        for (int i = 1; i <= 2 * WL; i++) begin
            tick();
            w = (i <= WL) ? 8'hFF : 8'h03;
            j = (i <= WL) ? i : i - WL;
            got = {x8, vld8, sof8, eof8, ready8};
            exp = {eb8(w, j), 1'b1, j == 1, j == WL, j == WL};
            total++;
            if (got !== exp) begin bad++; $display("FAIL b2b cyc%0d: got %b want %b", i, got, exp); end
            if (i == WL) data8 = 8'h03;
            if (i == 2 * WL) valid8 = 1'b0;
        end
        tick();
        got = {x8, vld8, sof8, eof8, ready8};
        total++;
        if (got !== 5'b00001) begin bad++; $display("FAIL b2b_idle: got %b want 00001", got); end
    endtask

    task automatic test_reset_mid();
        logic [4:0] got, exp;
        data8 = 8'hA5; valid8 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            valid8 = 1'b0;
            got = {x8, vld8, sof8, eof8, ready8};
            exp = {eb8(8'hA5, i), 1'b1, i == 1, 1'b0, 1'b0};
            total++;
            if (got !== exp) begin bad++; $display("FAIL rmid_pre cyc%0d: got %b want %b", i, got, exp); end
        end
        reset = 1'b1;
        #1;
        got = {x8, vld8, sof8, eof8, ready8};
        total++;
        if (got !== 5'b00001) begin bad++; $display("FAIL rmid_async: got %b want 00001", got); end
        tick();
        reset = 1'b0;
        tick();
        got = {x8, vld8, sof8, eof8, ready8};
        total++;
        if (got !== 5'b00001) begin bad++; $display("FAIL rmid_discard: got %b want 00001", got); end
        data8 = 8'h0F; valid8 = 1'b1;
        for (int i = 1; i <= WL; i++) begin
            tick();
            valid8 = 1'b0;
            got = {x8, vld8, sof8, eof8, ready8};
            exp = {eb8(8'h0F, i), 1'b1, i == 1, i == WL, i == WL};
            total++;
            if (got !== exp) begin bad++; $display("FAIL rmid_0f cyc%0d: got %b want %b", i, got, exp); end
        end
        tick();
    endtask

    task automatic test_ignore();
        logic [4:0] got, exp;
        data8 = 8'h3C; valid8 = 1'b1;
        for (int i = 1; i <= WL; i++) begin
            tick();
            got = {x8, vld8, sof8, eof8, ready8};
            exp = {eb8(8'h3C, i), 1'b1, i == 1, i == WL, i == WL};
            total++;
            if (got !== exp) begin bad++; $display("FAIL ignore cyc%0d: got %b want %b", i, got, exp); end
            if (i == 1) valid8 = 1'b0;
            if (i == 2) data8 = 8'hC3;
            if (i == 3) begin valid8 = 1'b1; data8 = 8'hFF; end
            if (i == 4) valid8 = 1'b0;
        end
        tick();
        got = {x8, vld8, sof8, eof8, ready8};
        total++;
        if (got !== 5'b00001) begin bad++; $display("FAIL ignore_idle: got %b want 00001", got); end
    endtask

`ifdef SER_PARITY_EN
    task automatic test_parity();
        logic [4:0] got, exp;
        logic [7:0] words [2];
        logic [8:0] bits  [2];
        words[0] = 8'h07; bits[0] = 9'b0000_0111_1;
        words[1] = 8'h03; bits[1] = 9'b0000_0011_0;
        for (int k = 0; k < 2; k++) begin
            data8 = words[k]; valid8 = 1'b1;
            for (int i = 1; i <= 9; i++) begin
                tick();
                valid8 = 1'b0;
                got = {x8, vld8, sof8, eof8, ready8};
                exp = {bits[k][9-i], 1'b1, i == 1, i == 9, i == 9};
                total++;
                if (got !== exp) begin bad++; $display("FAIL parity w%0d cyc%0d: got %b want %b", k, i, got, exp); end
            end
            tick();
        end
    endtask
`endif

    task automatic test_width2();
        logic [4:0] got, exp;
        logic [5:0] seq;
        int j;
        seq = (PB == 1) ? 6'b101011 : 6'b100100;
        data2 = 2'b10; valid2 = 1'b1;
        for (int i = 1; i <= 2 * WL2; i++) begin
            tick();
            j = (i <= WL2) ? i : i - WL2;
            got = {x2, vld2, sof2, eof2, ready2};
            exp = {seq[6-i], 1'b1, j == 1, j == WL2, j == WL2};
            total++;
            if (got !== exp) begin bad++; $display("FAIL w2 cyc%0d: got %b want %b", i, got, exp); end
            if (i == WL2) data2 = 2'b01;
            if (i == 2 * WL2) valid2 = 1'b0;
        end
        tick();
        got = {x2, vld2, sof2, eof2, ready2};
        total++;
        if (got !== 5'b00001) begin bad++; $display("FAIL w2_idle: got %b want 00001", got); end
    endtask

    task automatic test_div3();
        logic [63:0] w [3];
        logic [3:0]  got, exp;
        logic        b;
        int          exp_rem;
        w[0] = 64'd3;
        w[1] = {$urandom(), $urandom()};
        w[2] = {$urandom(), $urandom()};
        exp_rem = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        data64 = w[0]; valid64 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int j = 1; j <= WL64; j++) begin
                tick();
                b = eb64(w[k], j);
                exp_rem = (exp_rem * 2 + int'(b)) % 3;
                got = {x64, vld64, sof64, div_o};
                exp = {b, 1'b1, j == 1, exp_rem == 0};
                total++;
                if (got !== exp) begin bad++; $display("FAIL div3 w%0d bit%0d: got %b want %b", k, j, got, exp); end
                if (j == WL64) begin
                    if (k < 2) data64 = w[k+1];
                    else       valid64 = 1'b0;
                end
            end
        end
        tick();
        total++;
        if (vld64 !== 1'b0) begin bad++; $display("FAIL div3_idle: got %b want 0", vld64); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_ignore();
`ifdef SER_PARITY_EN
        test_parity();
`endif
        test_width2();
        test_div3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
